// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit with a memory-wait watchdog.
// Strobes decode combinationally from the registered state and the current
// OP/Function/Zero inputs. Retire pulse and sticky error flags are registered.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          TIMEOUT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Function,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       JalLink,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ShamtSelector,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic          supported;
  logic          waiting;
  logic          timeout;
  logic          retire;

  assign state     = state_q;
  assign supported = OP inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                                OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
  assign waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout   = TIMEOUT_EN && waiting && (wait_cnt == WAIT_MAX);
  assign retire    = (state_d == S_FETCH) &&
                     (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

  // Next-state and strobe decode; reset forces every strobe low.
  always_comb begin
    state_d       = state_q;
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    JalLink       = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ShamtSelector = 1'b0;
    PCSource      = 2'b00;
    ALUOp         = 3'b000;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (!supported) begin
          state_d = S_HALT;
        end else if ((OP == OP_J) || (OP == OP_JAL)) begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          RegWrite = (OP == OP_JAL);
          JalLink  = (OP == OP_JAL);
          state_d  = S_FETCH;
        end else if ((OP == OP_RTYPE) && (Function == FN_JR)) begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        case (OP)
          OP_RTYPE: begin
            ALUOp         = 3'b111;
            ShamtSelector = (Function == FN_SLL) || (Function == FN_SRL);
            state_d       = S_WB;
          end
          OP_BEQ, OP_BNE: begin
            ALUOp    = 3'b001;
            PCWrite  = (OP == OP_BEQ) ? Zero : !Zero;
            PCSource = 2'b01;
            state_d  = S_FETCH;
          end
          OP_ADDI, OP_ORI, OP_LUI: begin
            ALUSrcB = 2'b10;
            ALUOp   = (OP == OP_ADDI) ? 3'b100 : ((OP == OP_ORI) ? 3'b101 : 3'b110);
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            ALUSrcB = 2'b10;
            ALUOp   = 3'b100;
            state_d = S_MEM;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (OP == OP_LW);
        MemWrite = (OP == OP_SW);
        if (mem_ready) begin
          state_d = (OP == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (OP == OP_RTYPE);
        MemtoReg = (OP == OP_LW);
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      JalLink       = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ShamtSelector = 1'b0;
      PCSource      = 2'b00;
      ALUOp         = 3'b000;
    end
  end

  // State register, saturating wait counter, retire pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_done <= retire;
      if ((state_q == S_DECODE) && !supported) illegal_op <= 1'b1;
      if (timeout) bus_error <= 1'b1;
      if ((state_d != state_q) || !waiting) begin
        wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues per-cycle
// stimulus with the expected output vector, then replays and compares.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, Zero, mem_ready;
  logic [5:0] OP, Function;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, JalLink, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic       ShamtSelector, instr_done, illegal_op, bus_error;
  logic [2:0] ALUOp, state;

  logic       n_pcw, n_irw, n_iord, n_mrd, n_mwr, n_m2r, n_rdst, n_rw, n_jal, n_srca;
  logic [1:0] n_srcb, n_pcs;
  logic       n_sh, n_done, n_ill, n_bus;
  logic [2:0] n_aop, n_state;

  logic [23:0] obs, nobs;
  assign obs  = {state, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
                 JalLink, ALUSrcA, ALUSrcB, ShamtSelector, PCSource, ALUOp, instr_done, illegal_op, bus_error};
  assign nobs = {n_state, n_pcw, n_irw, n_iord, n_mrd, n_mwr, n_m2r, n_rdst, n_rw,
                 n_jal, n_srca, n_srcb, n_sh, n_pcs, n_aop, n_done, n_ill, n_bus};

  multicycle_control #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Function(Function), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .JalLink(JalLink), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ShamtSelector(ShamtSelector), .PCSource(PCSource), .ALUOp(ALUOp),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op), .bus_error(bus_error));

  multicycle_control #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .OP(OP), .Function(Function), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(n_pcw), .IRWrite(n_irw), .IorD(n_iord), .MemRead(n_mrd), .MemWrite(n_mwr),
    .MemtoReg(n_m2r), .RegDst(n_rdst), .RegWrite(n_rw), .JalLink(n_jal), .ALUSrcA(n_srca),
    .ALUSrcB(n_srcb), .ShamtSelector(n_sh), .PCSource(n_pcs), .ALUOp(n_aop),
    .state(n_state), .instr_done(n_done), .illegal_op(n_ill), .bus_error(n_bus));

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [23:0] exp;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected vector: state, {PCWrite..ALUSrcA}, ALUSrcB, Shamt, PCSource, ALUOp, {done,illegal,bus}.
  function automatic logic [23:0] ev(input logic [2:0] st, input logic [9:0] s, input logic [1:0] srcb,
                                     input logic sh, input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic [2:0] fl);
    return {st, s, srcb, sh, pcs, aop, fl};
  endfunction

  function automatic logic [23:0] f_rdy(input logic [2:0] fl);
    return ev(3'd0, 10'b1101000000, 2'b01, 1'b0, 2'b00, 3'b000, fl);
  endfunction

  function automatic logic [23:0] f_wait(input logic [2:0] fl);
    return ev(3'd0, 10'b0001000000, 2'b01, 1'b0, 2'b00, 3'b000, fl);
  endfunction

  function automatic logic [23:0] dec();
    return ev(3'd1, 10'b0000000000, 2'b11, 1'b0, 2'b00, 3'b000, 3'b000);
  endfunction

  function automatic logic [23:0] halt(input logic [2:0] fl);
    return ev(3'd7, 10'b0000000000, 2'b00, 1'b0, 2'b00, 3'b000, fl);
  endfunction

  task automatic push(input logic rst, input logic mr, input logic z, input logic [5:0] op,
                      input logic [5:0] fn, input logic [23:0] exp);
    ent_t e;
    e.rst = rst; e.mr = mr; e.z = z; e.op = op; e.fn = fn; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ent_t e;
    int   n = 0;
    push(1'b1, 1'b1, 1'b0, 6'h00, 6'h20, 24'h000000);
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, f_wait(3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, f_wait(3'b000));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL reset step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    ent_t e;
    int   n = 0;
    do_reset();
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, dec());
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, ev(3'd2, 10'b0000000001, 2'b00, 1'b0, 2'b00, 3'b111, 3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, ev(3'd4, 10'b0000001100, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, f_wait(3'b100));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, f_wait(3'b000));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL add step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype();
    ent_t e;
    int   n = 0;
    do_reset();
    // SLL then ORI back to back
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h00, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h00, dec());
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h00, ev(3'd2, 10'b0000000001, 2'b00, 1'b1, 2'b00, 3'b111, 3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h00, ev(3'd4, 10'b0000001100, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h0d, 6'h00, f_rdy(3'b100));
    push(1'b0, 1'b1, 1'b0, 6'h0d, 6'h00, dec());
    push(1'b0, 1'b1, 1'b0, 6'h0d, 6'h00, ev(3'd2, 10'b0000000001, 2'b10, 1'b0, 2'b00, 3'b101, 3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h0d, 6'h00, ev(3'd4, 10'b0000000100, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h0d, 6'h00, f_wait(3'b100));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL itype step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    ent_t e;
    int   n = 0;
    do_reset();
    push(1'b0, 1'b1, 1'b0, 6'h23, 6'h00, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h23, 6'h00, dec());
    push(1'b0, 1'b1, 1'b0, 6'h23, 6'h00, ev(3'd2, 10'b0000000001, 2'b10, 1'b0, 2'b00, 3'b100, 3'b000));
    for (int i = 0; i < 3; i++)
      push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, ev(3'd3, 10'b0011000000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    // ready on the last allowed wait cycle completes the access
    push(1'b0, 1'b1, 1'b0, 6'h23, 6'h00, ev(3'd3, 10'b0011000000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, ev(3'd4, 10'b0000010100, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h23, 6'h00, f_wait(3'b100));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL lw_wait step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branches();
    ent_t        e;
    int          n = 0;
    logic [5:0]  op;
    logic        z, taken;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      op    = (k < 2) ? 6'h04 : 6'h05;
      z     = (k % 2 == 0);
      taken = (k < 2) ? z : !z;
      push(1'b0, 1'b1, z, op, 6'h00, f_rdy(3'b000));
      push(1'b0, 1'b1, z, op, 6'h00, dec());
      push(1'b0, 1'b1, z, op, 6'h00, ev(3'd2, {taken, 9'b000000001}, 2'b00, 1'b0, 2'b01, 3'b001, 3'b000));
      push(1'b0, 1'b0, z, op, 6'h00, f_wait(3'b100));
    end
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL branch step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    ent_t e;
    int   n = 0;
    do_reset();
    push(1'b0, 1'b1, 1'b0, 6'h02, 6'h00, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h02, 6'h00, ev(3'd1, 10'b1000000000, 2'b11, 1'b0, 2'b10, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h02, 6'h00, f_wait(3'b100));
    push(1'b0, 1'b1, 1'b0, 6'h03, 6'h00, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h03, 6'h00, ev(3'd1, 10'b1000000110, 2'b11, 1'b0, 2'b10, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h03, 6'h00, f_wait(3'b100));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h08, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h08, ev(3'd1, 10'b1000000000, 2'b11, 1'b0, 2'b11, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h08, f_wait(3'b100));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL jump step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_reset();
    ent_t        e;
    int          n = 0;
    logic [23:0] ex_sw, mem_sw;
    ex_sw  = ev(3'd2, 10'b0000000001, 2'b10, 1'b0, 2'b00, 3'b100, 3'b000);
    mem_sw = ev(3'd3, 10'b0010100000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000);
    do_reset();
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, dec());
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, ex_sw);
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, mem_sw);
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, f_rdy(3'b100));
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, dec());
    push(1'b0, 1'b1, 1'b0, 6'h2b, 6'h00, ex_sw);
    push(1'b0, 1'b0, 1'b0, 6'h2b, 6'h00, mem_sw);
    push(1'b1, 1'b0, 1'b0, 6'h2b, 6'h00, ev(3'd3, 10'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h2b, 6'h00, f_wait(3'b000));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL sw_reset step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    ent_t e;
    int   n = 0;
    do_reset();
    push(1'b0, 1'b1, 1'b0, 6'h3f, 6'h00, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h3f, 6'h00, dec());
    push(1'b0, 1'b1, 1'b0, 6'h3f, 6'h00, halt(3'b010));
    push(1'b0, 1'b1, 1'b1, 6'h3f, 6'h00, halt(3'b010));
    push(1'b1, 1'b0, 1'b0, 6'h3f, 6'h00, halt(3'b010));
    push(1'b0, 1'b0, 1'b0, 6'h3f, 6'h00, f_wait(3'b000));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL illegal step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    ent_t e;
    int   n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, f_wait(3'b000));
    push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, halt(3'b001));
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL timeout step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
    // watchdog disabled: still waiting in FETCH without error
    checks++;
    if (nobs !== f_wait(3'b000)) begin
      failures++;
      $display("FAIL no_timeout: observed=%b expected=%b", nobs, f_wait(3'b000));
    end
    do_reset();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, f_wait(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, f_rdy(3'b000));
    push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, dec());
    n = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); n++;
      reset = e.rst; mem_ready = e.mr; Zero = e.z; OP = e.op; Function = e.fn;
      @(negedge clk);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL timeout_rescue step %0d: observed=%b expected=%b", n, obs, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0; OP = 6'h00; Function = 6'h00;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_itype();
    test_lw_wait();
    test_branches();
    test_jumps();
    test_sw_reset();
    test_illegal();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum consecutive cycles spent waiting for mem_ready in one memory access.
REQ-002 Parameter TIMEOUT_EN, default 1: 1 enables the memory-wait watchdog; 0 allows waiting indefinitely.
REQ-003 Reset is synchronous and active-high. The block has one clock, clk.
REQ-004 Ports, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- OP  in  6  instruction opcode
- Function  in  6  R-type funct field
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete
REQ-005 Outputs:
- PCWrite  out  1  PC write enable
- IRWrite  out  1  IR write enable
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemtoReg  out  1  register write data: 1 = MDR
- RegDst  out  1  destination register: 1 = rd
- RegWrite  out  1  register file write enable
- JalLink  out  1  write PC into $31
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- ShamtSelector  out  1  ALU A input = shamt
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs
- ALUOp  out  3  ALU operation
- state  out  3  current state
- instr_done  out  1  one-cycle pulse at instruction retire
- illegal_op  out  1  sticky flag
- bus_error  out  1  sticky flag

Function
REQ-006 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 go to FETCH on the next cycle.
REQ-007 All strobes are decoded combinationally from the registered state, OP, Function and Zero. An output not named for a state is 0 in that state.
REQ-008 ALUOp encodings: 000 = add, 001 = sub, 100 = ADDI, 101 = ORI, 110 = LUI, 111 = R-type funct decode.
REQ-009 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000.
- When mem_ready=1: IRWrite=1, PCWrite=1, PCSource=00, next state DECODE.
- Otherwise the state holds.
REQ-010 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Then, by instruction:
- J (OP 0x02): PCWrite=1, PCSource=10, go to FETCH.
- JAL (OP 0x03): as J, plus RegWrite=1 and JalLink=1.
- JR (OP 0, funct 0x08): PCWrite=1, PCSource=11, go to FETCH.
- Other supported opcodes: go to EXEC.
REQ-011 Supported opcodes: 0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x0d, 0x0f, 0x23 (LW), 0x2b (SW). In DECODE, any other opcode sets illegal_op and goes to HALT. No register or PC write occurs for an illegal opcode.
REQ-012 EXEC, by instruction class:
- R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=111, go to WB.
- SLL/SRL (funct 0x00/0x02): as R-type, plus ShamtSelector=1.
- ADDI/ORI/LUI: ALUSrcA=1, ALUSrcB=10, ALUOp=100/101/110 respectively, go to WB.
- LW/SW: ALUSrcA=1, ALUSrcB=10, ALUOp=100, go to MEM.
REQ-013 EXEC, branches: ALUSrcA=1, ALUSrcB=00, ALUOp=001.
- BEQ: PCWrite=Zero.
- BNE: PCWrite=!Zero.
- PCSource=01 for both; go to FETCH.
REQ-014 MEM: IorD=1; MemRead=1 for LW, MemWrite=1 for SW. The state holds until mem_ready=1, then LW goes to WB and SW goes to FETCH.
REQ-015 WB: RegWrite=1. RegDst=1 only for R-type. MemtoReg=1 only for LW. Go to FETCH.
REQ-016 instr_done=1 on every transition into FETCH from DECODE, EXEC, MEM or WB. It is never asserted on reset exit or in HALT.
REQ-017 Watchdog: a wait counter counts cycles in FETCH or MEM with mem_ready=0. It clears on any state change and whenever mem_ready=1.
REQ-018 When TIMEOUT_EN=1 and the counter reaches MEM_TIMEOUT-1 while mem_ready=0, the next state is HALT and bus_error is set. mem_ready=1 on that same cycle takes priority: the access completes normally.
REQ-019 HALT: all strobes are 0; the block stays in HALT until reset. illegal_op and bus_error hold.
REQ-020 The counter width is clog2(MEM_TIMEOUT)+1. The counter saturates and never wraps.

Reset
REQ-021 On reset=1 at a clk edge: state becomes FETCH, the wait counter clears, and illegal_op, bus_error and instr_done become 0. Reset mid-instruction, including in MEM with MemWrite asserted, aborts the instruction with no further strobes.
REQ-022 While reset=1, all strobe outputs are forced to 0.

Verification
REQ-023 ADD (OP 0, funct 0x20), mem_ready=1 throughout: states 0,1,2,4,0; RegWrite=1 and RegDst=1 in WB only; instr_done pulses once.
REQ-024 LW with mem_ready held low 3 cycles in MEM: MemRead=1 and IorD=1 for 4 cycles, then WB with MemtoReg=1; total 8 cycles.
REQ-025 BEQ with Zero=1, then with Zero=0: PCWrite=1 in EXEC only for Zero=1, PCSource=01; BNE gives the inverse.
REQ-026 JAL: PCWrite, RegWrite and JalLink all 1 in DECODE; next state FETCH; no EXEC cycle.
REQ-027 With MEM_TIMEOUT=4 and mem_ready=0 in FETCH: HALT after 4 cycles, bus_error=1. In a second run, mem_ready=1 on the 4th cycle gives DECODE with no error.
REQ-028 OP=0x3f: illegal_op=1, state 7; RegWrite and PCWrite never asserted. Reset mid-MEM for SW: FETCH next cycle, MemWrite=0, flags cleared.
